// File: rtl/approx_pkg.sv
// Shared types and defaults for the approximate arithmetic units.
// Used by approx_seq_divider and its masked subtractor.
package approx_pkg;

    localparam int DW_DEF     = 16;
    localparam int VW_DEF     = 8;
    localparam int MASK_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef logic [MASK_W_DEF-1:0] mask_t;

endpackage

// File: rtl/approx_masked_sub.sv
// Ripple-borrow subtractor a - b whose low MASK_W bits can drop the
// borrow-in under mask control; upper bits are always exact.
module approx_masked_sub
    import approx_pkg::*;
#(
    parameter int W      = VW_DEF + 1,
    parameter int MASK_W = MASK_W_DEF
) (
    input  logic [W-1:0]      a_i,
    input  logic [W-1:0]      b_i,
    input  logic [MASK_W-1:0] mask_i,
    output logic [W-1:0]      diff_o,
    output logic              borrow_o
);

    logic [W-1:0] exact;

    assign exact = {{(W-MASK_W){1'b1}}, mask_i};

    always_comb begin
        logic bw;
        bw     = 1'b0;
        diff_o = '0;
        for (int i = 0; i < W; i++) begin
            if (exact[i]) begin
                diff_o[i] = a_i[i] ^ b_i[i] ^ bw;
                bw        = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bw);
            end else begin
                diff_o[i] = a_i[i] ^ b_i[i];
                bw        = ~a_i[i] & b_i[i];
            end
        end
        borrow_o = bw;
    end

endmodule

// File: rtl/approx_seq_divider.sv
// Restoring divider, one quotient bit per cycle, with masked subtractor.
// Optional APPROX_DIV_EARLY_EXIT_EN: finish at once when dividend < divisor.
module approx_seq_divider
    import approx_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int VW     = VW_DEF,
    parameter int MASK_W = MASK_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     dividend,
    input  logic [VW-1:0]     divisor,
    input  logic [MASK_W-1:0] mask_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     quotient,
    output logic [VW-1:0]     remainder,
    output logic              div_zero
);

    localparam int CW = $clog2(DW);

    div_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     dvd_q, dvd_d;
    logic [VW-1:0]     dvs_q, dvs_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [VW-1:0]     r_q, r_d;
    logic [DW-1:0]     quo_q, quo_d;
    logic              dz_q, dz_d;

    logic [VW:0]       r_shift;
    logic [VW:0]       sub_diff;
    logic              sub_borrow;
    logic              unused_diff_msb;

    // A non-restored remainder never exceeds VW bits, so the MSB is dropped.
    assign r_shift         = {r_q, dvd_q[cnt_q]};
    assign unused_diff_msb = sub_diff[VW];

    approx_masked_sub #(
        .W      (VW + 1),
        .MASK_W (MASK_W)
    ) u_sub (
        .a_i      (r_shift),
        .b_i      ({1'b0, dvs_q}),
        .mask_i   (mask_q),
        .diff_o   (sub_diff),
        .borrow_o (sub_borrow)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        mask_d  = mask_q;
        r_d     = r_q;
        quo_d   = quo_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    mask_d = mask_x;
                    r_d    = '0;
                    quo_d  = '0;
                    dz_d   = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        r_d     = dividend[VW-1:0];
                        dz_d    = 1'b1;
`ifdef APPROX_DIV_EARLY_EXIT_EN
                    end else if (dividend < {{(DW-VW){1'b0}}, divisor}) begin
                        state_d = DONE;
                        r_d     = dividend[VW-1:0];
`endif
                    end else begin
                        state_d = RUN;
                        cnt_d   = CW'(DW - 1);
                    end
                end
            end
            RUN: begin
                r_d   = sub_borrow ? r_shift[VW-1:0] : sub_diff[VW-1:0];
                quo_d = {quo_q[DW-2:0], ~sub_borrow};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    dz_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            mask_q  <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            mask_q  <= mask_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = r_q;
    assign div_zero  = dz_q;

endmodule
